// File: rtl/turbo_rx_pb_sched.sv
// PB scheduler for the HPGP turbo RX interleaver: fills each PB into one of two RAM
// regions and issues one read window per PB, keeping writes and reads of a region apart.
module turbo_rx_pb_sched #(
    parameter int D_WIDTH   = 2,
    parameter int A_WIDTH   = 12,
    parameter int NPB_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cfg_vld,
    input  logic [1:0]           cfg_pb_sel,
    input  logic [NPB_WIDTH-1:0] cfg_num_pb,
    input  logic                 cfg_mode,
    output logic                 cfg_rdy,
    input  logic [D_WIDTH-1:0]   in_data,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic                 wen,
    output logic [A_WIDTH-1:0]   waddr,
    output logic [D_WIDTH-1:0]   wdata,
    output logic                 start,
    output logic [A_WIDTH-1:0]   pb_offset,
    output logic [A_WIDTH-1:0]   pb_len,
    output logic                 mod_int_dint,
    output logic [NPB_WIDTH-1:0] pb_idx,
    output logic                 frame_done,
    output logic                 cfg_err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} w_state_e;
    typedef enum logic {R_IDLE, R_READ} r_state_e;

    localparam logic [A_WIDTH-1:0] HALF_BASE = A_WIDTH'(1) << (A_WIDTH - 1);

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic                   act_q, act_d;
    logic                   pp_q, pp_d;
    logic [NPB_WIDTH-1:0]   num_pb_q, num_pb_d;
    logic [A_WIDTH-1:0]     pb_len_q, pb_len_d;
    logic                   mode_q, mode_d;
    logic [1:0]             full_q, full_d;
    logic                   wbuf_q, wbuf_d;
    logic                   rbuf_q, rbuf_d;
    logic [A_WIDTH-1:0]     wcnt_q, wcnt_d;
    logic [A_WIDTH-1:0]     rcnt_q, rcnt_d;
    logic [NPB_WIDTH-1:0]   wpb_q, wpb_d;
    logic [NPB_WIDTH-1:0]   pb_idx_q, pb_idx_d;
    logic                   wen_q, wen_d;
    logic [A_WIDTH-1:0]     waddr_q, waddr_d;
    logic [D_WIDTH-1:0]     wdata_q, wdata_d;
    logic                   start_q, start_d;
    logic [A_WIDTH-1:0]     pb_offset_q, pb_offset_d;
    logic                   frame_done_q, frame_done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [1:0]             set_full, clr_full;
    logic                   tgt;

    // Valid/ready: a config transfers when cfg_vld && cfg_rdy, a symbol when
    // in_vld && in_rdy, both on the rising clk edge; nothing transfers otherwise.
    always_comb begin
        w_state_d    = w_state_q;
        r_state_d    = r_state_q;
        act_d        = act_q;
        pp_d         = pp_q;
        num_pb_d     = num_pb_q;
        pb_len_d     = pb_len_q;
        mode_d       = mode_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        wpb_d        = wpb_q;
        pb_idx_d     = pb_idx_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        start_d      = 1'b0;
        pb_offset_d  = pb_offset_q;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        set_full     = 2'b00;
        clr_full     = 2'b00;
        tgt          = wbuf_q;

        if (cfg_vld && !act_q) begin
            if (cfg_pb_sel == 2'd3 || cfg_num_pb == '0) begin
                cfg_err_d = 1'b1;
            end else begin
                act_d     = 1'b1;
                w_state_d = W_FILL;
                pp_d      = (cfg_pb_sel != 2'd2);
                num_pb_d  = cfg_num_pb;
                mode_d    = cfg_mode;
                wbuf_d    = 1'b0;
                rbuf_d    = 1'b0;
                wcnt_d    = '0;
                rcnt_d    = '0;
                wpb_d     = '0;
                pb_idx_d  = '0;
                case (cfg_pb_sel)
                    2'd0:    pb_len_d = A_WIDTH'(12'h040);
                    2'd1:    pb_len_d = A_WIDTH'(12'h220);
                    default: pb_len_d = A_WIDTH'(12'h820);
                endcase
            end
        end

        case (w_state_q)
            W_FILL: begin
                if (in_vld) begin
                    wen_d   = 1'b1;
                    waddr_d = (wbuf_q ? HALF_BASE : '0) + wcnt_q;
                    wdata_d = in_data;
                    wcnt_d  = wcnt_q + A_WIDTH'(1);
                    if (wcnt_q == pb_len_q - A_WIDTH'(1)) begin
                        set_full[wbuf_q] = 1'b1;
                        wcnt_d           = '0;
                        wpb_d            = wpb_q + NPB_WIDTH'(1);
                        if (wpb_q + NPB_WIDTH'(1) == num_pb_q) begin
                            w_state_d = W_IDLE;
                        end else begin
                            // 520 B reuses the region just filled, so it always waits.
                            tgt    = pp_q ? ~wbuf_q : wbuf_q;
                            wbuf_d = tgt;
                            if (full_q[tgt] || tgt == wbuf_q) begin
                                w_state_d = W_WAIT;
                            end
                        end
                    end
                end
            end
            W_WAIT: begin
                if (!full_q[wbuf_q]) begin
                    w_state_d = W_FILL;
                end
            end
            default: ;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (act_q && full_q[rbuf_q]) begin
                    start_d     = 1'b1;
                    pb_offset_d = rbuf_q ? HALF_BASE : '0;
                    rcnt_d      = '0;
                    r_state_d   = R_READ;
                end
            end
            default: begin
                // Window is pb_len reads plus two cycles of interleaver pipeline.
                if (rcnt_q == pb_len_q + A_WIDTH'(1)) begin
                    clr_full[rbuf_q] = 1'b1;
                    if (pp_q) begin
                        rbuf_d = ~rbuf_q;
                    end
                    pb_idx_d  = pb_idx_q + NPB_WIDTH'(1);
                    r_state_d = R_IDLE;
                    if (pb_idx_q + NPB_WIDTH'(1) == num_pb_q) begin
                        frame_done_d = 1'b1;
                        act_d        = 1'b0;
                    end
                end else begin
                    rcnt_d = rcnt_q + A_WIDTH'(1);
                end
            end
        endcase

        full_d = (full_q | set_full) & ~clr_full;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            act_q        <= 1'b0;
            pp_q         <= 1'b0;
            num_pb_q     <= '0;
            pb_len_q     <= '0;
            mode_q       <= 1'b0;
            full_q       <= 2'b00;
            wbuf_q       <= 1'b0;
            rbuf_q       <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wpb_q        <= '0;
            pb_idx_q     <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            start_q      <= 1'b0;
            pb_offset_q  <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            act_q        <= act_d;
            pp_q         <= pp_d;
            num_pb_q     <= num_pb_d;
            pb_len_q     <= pb_len_d;
            mode_q       <= mode_d;
            full_q       <= full_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wpb_q        <= wpb_d;
            pb_idx_q     <= pb_idx_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            start_q      <= start_d;
            pb_offset_q  <= pb_offset_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    ap_full_set_clr_disjoint: assert property (@(posedge clk) disable iff (!n_rst)
        (set_full & clr_full) == 2'b00);

    assign cfg_rdy      = !act_q;
    assign in_rdy       = (w_state_q == W_FILL);
    assign wen          = wen_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign start        = start_q;
    assign pb_offset    = pb_offset_q;
    assign pb_len       = pb_len_q;
    assign mod_int_dint = mode_q;
    assign pb_idx       = pb_idx_q;
    assign frame_done   = frame_done_q;
    assign cfg_err      = cfg_err_q;
    assign dbg_state    = {r_state_q, w_state_q};

endmodule

// File: tb/tb_turbo_rx_pb_sched.sv
// Bench for turbo_rx_pb_sched: random symbol streams checked against a PB-level model
// of addresses, start windows, buffer reuse and frame completion.
module tb_turbo_rx_pb_sched;
    localparam int D_WIDTH   = 2;
    localparam int A_WIDTH   = 12;
    localparam int NPB_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b0;
    logic                 cfg_vld = 1'b0;
    logic [1:0]           cfg_pb_sel = '0;
    logic [NPB_WIDTH-1:0] cfg_num_pb = '0;
    logic                 cfg_mode = 1'b0;
    logic                 cfg_rdy;
    logic [D_WIDTH-1:0]   in_data = '0;
    logic                 in_vld = 1'b0;
    logic                 in_rdy;
    logic                 wen;
    logic [A_WIDTH-1:0]   waddr;
    logic [D_WIDTH-1:0]   wdata;
    logic                 start;
    logic [A_WIDTH-1:0]   pb_offset;
    logic [A_WIDTH-1:0]   pb_len;
    logic                 mod_int_dint;
    logic [NPB_WIDTH-1:0] pb_idx;
    logic                 frame_done;
    logic                 cfg_err;
    logic [2:0]           dbg_state;

    turbo_rx_pb_sched #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .NPB_WIDTH(NPB_WIDTH)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_vld(cfg_vld), .cfg_pb_sel(cfg_pb_sel),
        .cfg_num_pb(cfg_num_pb), .cfg_mode(cfg_mode), .cfg_rdy(cfg_rdy),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .wen(wen), .waddr(waddr),
        .wdata(wdata), .start(start), .pb_offset(pb_offset), .pb_len(pb_len),
        .mod_int_dint(mod_int_dint), .pb_idx(pb_idx), .frame_done(frame_done),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: accepted symbols (expected write stream) and observed DUT events
    logic [D_WIDTH-1:0]   exp_q[$];
    int                   acc_cyc_q[$];
    int                   wr_cyc_q[$];
    logic [A_WIDTH-1:0]   wr_addr_q[$];
    logic [D_WIDTH-1:0]   wr_data_q[$];
    int                   st_cyc_q[$];
    logic [A_WIDTH-1:0]   st_off_q[$];
    logic [A_WIDTH-1:0]   st_len_q[$];
    logic                 st_mode_q[$];
    logic [NPB_WIDTH-1:0] st_idx_q[$];
    int                   fd_cyc_q[$];
    logic                 fd_rdy_q[$];
    int                   err_cnt = 0;

    always @(negedge clk) begin
        if (wen) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(waddr);
            wr_data_q.push_back(wdata);
        end
        if (start) begin
            st_cyc_q.push_back(cyc);
            st_off_q.push_back(pb_offset);
            st_len_q.push_back(pb_len);
            st_mode_q.push_back(mod_int_dint);
            st_idx_q.push_back(pb_idx);
        end
        if (frame_done) begin
            fd_cyc_q.push_back(cyc);
            fd_rdy_q.push_back(cfg_rdy);
        end
        if (cfg_err) err_cnt++;
    end

    // driver tasks
    task automatic clear_mon();
        exp_q.delete(); acc_cyc_q.delete();
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        st_cyc_q.delete(); st_off_q.delete(); st_len_q.delete();
        st_mode_q.delete(); st_idx_q.delete();
        fd_cyc_q.delete(); fd_rdy_q.delete();
        err_cnt = 0;
    endtask

    task automatic apply_cfg(input logic [1:0] sel, input logic [NPB_WIDTH-1:0] num,
                             input logic mode);
        cfg_pb_sel = sel;
        cfg_num_pb = num;
        cfg_mode   = mode;
        cfg_vld    = 1'b1;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
    endtask

    task automatic feed(input int n, input int duty, input int budget, input bit poke,
                        output bit ok);
        int got = 0;
        int waited = 0;
        ok = 1'b1;
        while (got < n) begin
            in_vld  = (int'($urandom_range(99)) < duty);
            in_data = D_WIDTH'($urandom);
            if (poke && waited == 5) begin
                cfg_vld    = 1'b1;
                cfg_pb_sel = 2'd0;
                cfg_num_pb = NPB_WIDTH'(1);
                cfg_mode   = ~cfg_mode;
            end
            @(negedge clk);
            if (in_vld && in_rdy) begin
                exp_q.push_back(in_data);
                acc_cyc_q.push_back(cyc);
                got++;
            end
            @(posedge clk); #1;
            cfg_vld = 1'b0;
            in_vld  = 1'b0;
            waited++;
            if (waited > budget) begin
                ok = 1'b0;
                break;
            end
        end
        in_vld = 1'b0;
    endtask

    // generic frame scenario: drive a frame, then check it against the PB-level model
    task automatic test_frame(input string name, input logic [1:0] sel, input int num,
                              input logic mode, input int duty, input bit poke);
        int len, reuse, base, w, nerr, first_bad;
        bit pp, ok;
        logic [A_WIDTH-1:0] got_a, exp_a;
        len = (sel == 2'd0) ? 'h40 : (sel == 2'd1) ? 'h220 : 'h820;
        pp  = (sel != 2'd2);
        clear_mon();
        apply_cfg(sel, NPB_WIDTH'(num), mode);
        @(negedge clk);
        total++;
        if (cfg_rdy !== 1'b0) begin
            bad++; $display("FAIL %s cfg_rdy_busy: got %b want 0", name, cfg_rdy);
        end
        @(posedge clk); #1;
        feed(num * len, duty, 40000, poke, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++; $display("FAIL %s feed_timeout: accepted %0d want %0d", name, exp_q.size(), num * len);
        end
        w = 0;
        while (fd_cyc_q.size() == 0 && w < 20000) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (4) @(posedge clk);
        #1;

        total++;
        if (wr_addr_q.size() != num * len) begin
            bad++; $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), num * len);
        end
        nerr = 0; first_bad = -1; got_a = '0; exp_a = '0;
        for (int j = 0; j < wr_addr_q.size() && j < exp_q.size(); j++) begin
            base = (pp && ((j / len) % 2 == 1)) ? 'h800 : 0;
            if (wr_addr_q[j] !== A_WIDTH'(base + j % len) || wr_data_q[j] !== exp_q[j] ||
                wr_cyc_q[j] != acc_cyc_q[j] + 1) begin
                nerr++;
                if (first_bad < 0) begin
                    first_bad = j; got_a = wr_addr_q[j]; exp_a = A_WIDTH'(base + j % len);
                end
            end
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL %s write_stream: %0d bad writes, first #%0d addr got %h want %h",
                            name, nerr, first_bad, got_a, exp_a);
        end

        total++;
        if (st_cyc_q.size() != num) begin
            bad++; $display("FAIL %s start_count: got %0d want %0d", name, st_cyc_q.size(), num);
        end
        for (int k = 0; k < num && k < st_cyc_q.size(); k++) begin
            base = (pp && (k % 2 == 1)) ? 'h800 : 0;
            total++;
            if (st_off_q[k] !== A_WIDTH'(base) || st_len_q[k] !== A_WIDTH'(len) ||
                st_mode_q[k] !== mode || st_idx_q[k] !== NPB_WIDTH'(k)) begin
                bad++; $display("FAIL %s start_fields pb%0d: off/len/mode/idx got %h/%h/%b/%0d want %h/%h/%b/%0d",
                                name, k, st_off_q[k], st_len_q[k], st_mode_q[k], st_idx_q[k],
                                base, len, mode, k);
            end
            if ((k + 1) * len - 1 < acc_cyc_q.size()) begin
                total++;
                if (st_cyc_q[k] < acc_cyc_q[(k + 1) * len - 1] + 2) begin
                    bad++; $display("FAIL %s early_start pb%0d: start cyc %0d want >= %0d",
                                    name, k, st_cyc_q[k], acc_cyc_q[(k + 1) * len - 1] + 2);
                end
            end
            if (k > 0) begin
                total++;
                if (st_cyc_q[k] - st_cyc_q[k - 1] < len + 3) begin
                    bad++; $display("FAIL %s start_spacing pb%0d: got %0d want >= %0d",
                                    name, k, st_cyc_q[k] - st_cyc_q[k - 1], len + 3);
                end
            end
            reuse = pp ? k - 2 : k - 1;
            if (reuse >= 0 && k * len < acc_cyc_q.size()) begin
                total++;
                if (acc_cyc_q[k * len] < st_cyc_q[reuse] + len + 2) begin
                    bad++; $display("FAIL %s overwrite pb%0d: first accept cyc %0d want >= %0d",
                                    name, k, acc_cyc_q[k * len], st_cyc_q[reuse] + len + 2);
                end
            end
        end

        total++;
        if (fd_cyc_q.size() != 1) begin
            bad++; $display("FAIL %s frame_done_count: got %0d want 1", name, fd_cyc_q.size());
        end
        if (fd_cyc_q.size() >= 1 && st_cyc_q.size() >= 1) begin
            total++;
            if (fd_cyc_q[0] != st_cyc_q[st_cyc_q.size() - 1] + len + 2) begin
                bad++; $display("FAIL %s frame_done_time: got cyc %0d want %0d", name, fd_cyc_q[0],
                                st_cyc_q[st_cyc_q.size() - 1] + len + 2);
            end
            total++;
            if (fd_rdy_q[0] !== 1'b1) begin
                bad++; $display("FAIL %s cfg_rdy_at_done: got %b want 1", name, fd_rdy_q[0]);
            end
        end
        total++;
        if (err_cnt != 0) begin
            bad++; $display("FAIL %s spurious_cfg_err: got %0d want 0", name, err_cnt);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cfg_rdy, in_rdy, wen, start, frame_done, cfg_err, mod_int_dint} !== 7'b1000000) begin
            bad++; $display("FAIL reset_flags: got %b want 1000000",
                            {cfg_rdy, in_rdy, wen, start, frame_done, cfg_err, mod_int_dint});
        end
        total++;
        if ({waddr, wdata, pb_offset, pb_len, pb_idx, dbg_state} !== '0) begin
            bad++; $display("FAIL reset_values: waddr %h wdata %h off %h len %h idx %h st %h want all 0",
                            waddr, wdata, pb_offset, pb_len, pb_idx, dbg_state);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_16b();
        test_frame("pb16x1", 2'd0, 1, 1'($urandom_range(1)), 100, 1'b0);
        if (st_cyc_q.size() == 1 && acc_cyc_q.size() == 64) begin
            total++;
            if (st_cyc_q[0] != acc_cyc_q[63] + 2) begin
                bad++; $display("FAIL pb16x1 start_latency: got cyc %0d want %0d", st_cyc_q[0], acc_cyc_q[63] + 2);
            end
        end
    endtask

    task automatic test_136b();
        test_frame("pb136x3", 2'd1, 3, 1'($urandom_range(1)), 100, 1'b1);
        if (st_cyc_q.size() >= 1 && acc_cyc_q.size() == 3 * 'h220) begin
            total++;
            if (acc_cyc_q['h220] >= st_cyc_q[0] + 'h220 + 2) begin
                bad++; $display("FAIL pb136x3 pb1_overlap: pb1 accept cyc %0d want < %0d",
                                acc_cyc_q['h220], st_cyc_q[0] + 'h220 + 2);
            end
            total++;
            if (acc_cyc_q[2 * 'h220] - acc_cyc_q[2 * 'h220 - 1] < 2) begin
                bad++; $display("FAIL pb136x3 pb2_stall: gap %0d want >= 2",
                                acc_cyc_q[2 * 'h220] - acc_cyc_q[2 * 'h220 - 1]);
            end
        end
    endtask

    task automatic test_520b();
        test_frame("pb520x2", 2'd2, 2, 1'($urandom_range(1)), 100, 1'b0);
        if (acc_cyc_q.size() == 2 * 'h820) begin
            total++;
            if (acc_cyc_q['h820] - acc_cyc_q['h820 - 1] < 'h820) begin
                bad++; $display("FAIL pb520x2 in_rdy_stall: gap %0d want >= %0d",
                                acc_cyc_q['h820] - acc_cyc_q['h820 - 1], 'h820);
            end
        end
    endtask

    task automatic test_gaps();
        test_frame("pb136x2_gaps", 2'd1, 2, 1'($urandom_range(1)), 50, 1'b0);
    endtask

    task automatic test_cfg_err(input string name, input logic [1:0] sel,
                                input logic [NPB_WIDTH-1:0] num);
        clear_mon();
        apply_cfg(sel, num, 1'b1);
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b1 || cfg_rdy !== 1'b1) begin
            bad++; $display("FAIL %s err_pulse: cfg_err %b cfg_rdy %b want 1 1", name, cfg_err, cfg_rdy);
        end
        @(posedge clk); #1;
        in_vld = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        in_vld = 1'b0;
        total++;
        if (wr_addr_q.size() != 0 || st_cyc_q.size() != 0 || cfg_rdy !== 1'b1) begin
            bad++; $display("FAIL %s no_activity: wen %0d start %0d cfg_rdy %b want 0 0 1",
                            name, wr_addr_q.size(), st_cyc_q.size(), cfg_rdy);
        end
        total++;
        if (err_cnt != 1) begin
            bad++; $display("FAIL %s err_count: got %0d want 1", name, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        apply_cfg(2'd1, NPB_WIDTH'(2), 1'b1);
        @(posedge clk); #1;
        feed('h220 + 20, 100, 5000, 1'b0, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++; $display("FAIL rst_mid feed_timeout: accepted %0d want %0d", exp_q.size(), 'h220 + 20);
        end
        n_rst = 1'b0;
        #1;
        total++;
        if ({cfg_rdy, in_rdy, wen, start, frame_done, cfg_err, mod_int_dint} !== 7'b1000000) begin
            bad++; $display("FAIL rst_mid flags: got %b want 1000000",
                            {cfg_rdy, in_rdy, wen, start, frame_done, cfg_err, mod_int_dint});
        end
        total++;
        if ({waddr, wdata, pb_offset, pb_len, pb_idx, dbg_state} !== '0) begin
            bad++; $display("FAIL rst_mid values: waddr %h wdata %h off %h len %h idx %h st %h want all 0",
                            waddr, wdata, pb_offset, pb_len, pb_idx, dbg_state);
        end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        clear_mon();
        in_vld = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        in_vld = 1'b0;
        total++;
        if (wr_addr_q.size() != 0 || st_cyc_q.size() != 0) begin
            bad++; $display("FAIL rst_mid discarded: wen %0d start %0d want 0 0", wr_addr_q.size(), st_cyc_q.size());
        end
        test_frame("rst_rerun", 2'd0, 1, 1'($urandom_range(1)), 100, 1'b0);
    endtask

    initial begin
        test_reset();
        test_16b();
        test_136b();
        test_520b();
        test_cfg_err("err_sel3", 2'd3, NPB_WIDTH'($urandom_range(1, 255)));
        test_cfg_err("err_num0", 2'($urandom_range(2)), '0);
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
